// File: rtl/match_filter_pkg.sv
// Shared constants and types for the match_filter operand-match pipeline.
package match_filter_pkg;

    localparam int HIT_COUNT_W = 16;
    localparam logic [HIT_COUNT_W-1:0] HIT_COUNT_MAX = '1;

    typedef struct packed {
        logic hit;
    } s1_payload_t;

endpackage

// File: rtl/match_filter_if.sv
// Config, input and output handshake bundle for match_filter; slave is the filter side.
interface match_filter_if #(
    parameter int WIDTH = 11,
    parameter int NUM_A = 2
);
    import match_filter_pkg::*;

    localparam int SEL_W = $clog2(NUM_A + 1);

    logic                   cfg_we;
    logic [SEL_W-1:0]       cfg_sel;
    logic [WIDTH-1:0]       cfg_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_c;
    logic                   out_hit;
    logic [HIT_COUNT_W-1:0] hit_count;

    modport master (
        output cfg_we, cfg_sel, cfg_data, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_hit, hit_count
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_hit, hit_count
    );

endinterface

// File: rtl/match_filter_table.sv
// Programmable A-key table with per-entry enables plus a single B key.
// Produces a combinational hit from the live table contents.
module match_filter_table
    import match_filter_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int NUM_A = 2,
    parameter int SEL_W = $clog2(NUM_A + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             hit
);

    logic [WIDTH-1:0] a_key [NUM_A];
    logic [NUM_A-1:0] a_en;
    logic [WIDTH-1:0] b_key;
    logic             a_match;

    // Selects above NUM_A match neither branch and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_A; i++) begin
                a_key[i] <= '0;
            end
            a_en  <= '0;
            b_key <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_A; i++) begin
                if (cfg_sel == SEL_W'(i)) begin
                    a_key[i] <= cfg_data;
                    a_en[i]  <= 1'b1;
                end
            end
            if (cfg_sel == SEL_W'(NUM_A)) begin
                b_key <= cfg_data;
            end
        end
    end

    always_comb begin
        a_match = 1'b0;
        for (int i = 0; i < NUM_A; i++) begin
            a_match = a_match | (a_en[i] & (in_a == a_key[i]));
        end
        hit = a_match & (in_b == b_key);
    end

endmodule

// File: rtl/match_filter.sv
// Two-stage valid/ready operand-match filter with a saturating hit counter.
// Optional feature macro: MATCH_FILTER_COUNT_EN (hit counter; tied to 0 when undefined).
module match_filter
    import match_filter_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int NUM_A    = 2,
    parameter int OUT_HIT  = 0,
    parameter int OUT_MISS = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    match_filter_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_A + 1);

    logic             table_hit;
    logic             accept;
    logic             s1_adv;
    logic             s1_valid;
    s1_payload_t      s1_data;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_c;
    logic             s2_hit;

    match_filter_table #(
        .WIDTH (WIDTH),
        .NUM_A (NUM_A),
        .SEL_W (SEL_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (bus.cfg_we),
        .cfg_sel  (bus.cfg_sel),
        .cfg_data (bus.cfg_data),
        .in_a     (bus.in_a),
        .in_b     (bus.in_b),
        .hit      (table_hit)
    );

    assign s1_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = rst_n && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    // table_hit reflects pre-write contents, so a same-cycle cfg write only affects later accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (accept) begin
            s1_valid     <= 1'b1;
            s1_data.hit  <= table_hit;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_c     <= WIDTH'(OUT_MISS);
            s2_hit   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_c   <= s1_data.hit ? WIDTH'(OUT_HIT) : WIDTH'(OUT_MISS);
                s2_hit <= s1_data.hit;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_c     = s2_c;
    assign bus.out_hit   = s2_hit;

`ifdef MATCH_FILTER_COUNT_EN
    logic [HIT_COUNT_W-1:0] hit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_hit && (hit_cnt != HIT_COUNT_MAX)) begin
            hit_cnt <= hit_cnt + HIT_COUNT_W'(1);
        end
    end

    assign bus.hit_count = hit_cnt;
`else
    assign bus.hit_count = '0;
`endif

endmodule

// File: doc/match_filter.md
Name: match_filter

Overview:
- Registered, parametrised operand-match filter for the MIPS simulator datapath; generalises the fixed "(a in {5,3}) and b==5" check.
- Operand A is compared against a programmable table of NUM_A keys; operand B is compared against one programmable key.
- The block emits OUT_HIT on a match and OUT_MISS otherwise, through a 2-stage valid/ready pipeline with a hit counter.

Parameters:
- WIDTH, 11: operand, key and result width.
- NUM_A, 2: number of A-key table entries (>=1).
- OUT_HIT, 0: out_c value on a match.
- OUT_MISS, 15: out_c value on a miss.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  $clog2(NUM_A+1)  0..NUM_A-1 selects A entry; NUM_A selects B key.
- cfg_data  in  WIDTH  key value to write.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_c  out  WIDTH  OUT_HIT or OUT_MISS.
- out_hit  out  1  1 on a match.
- hit_count  out  16  count of accepted hit results.

Behaviour:
- Table state
  - a_key[i] plus a per-entry enable bit a_en[i]; b_key.
  - Reset: all a_key=0, a_en=0, b_key=0.
  - Write to entry i: a_key[i]<=cfg_data, a_en[i]<=1.
  - Write with cfg_sel==NUM_A: b_key<=cfg_data.
  - Write with cfg_sel>NUM_A: ignored.
- Match rule: hit = (OR over i of a_en[i] & in_a==a_key[i]) & (in_b==b_key). With no entry enabled, every result is a miss.
- Stage 1 captures the compare result on accept, using table contents from before any same-cycle write. A write in cycle t affects transactions accepted from cycle t+1.
- Stage 2 holds out_c, out_hit and out_valid.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Flow control
  - s1 advances when !s2_valid | out_ready.
  - in_ready = !s1_valid | s1 advance (combinational).
  - Outputs stay stable while out_valid & !out_ready.
- Reset values: in_ready=0 while rst_n=0, otherwise 1; out_valid=0; out_c=OUT_MISS; out_hit=0; hit_count=0.
- Reset mid-operation: both stages are flushed, in-flight results are dropped, and the table is cleared.
- hit_count
  - Increments on out_valid & out_ready & out_hit.
  - Saturates at 16'hFFFF and does not wrap.
- Simultaneous cfg write and input accept: legal, with the ordering given above.

Optional Feature:
- Macro: MATCH_FILTER_COUNT_EN.
- Defined: hit_count behaves as described above.
- Undefined: no counter register; hit_count is tied to 0. All other behaviour is identical.

Decomposition:
- Package match_filter_pkg:
  - HIT_COUNT_W=16 and the HIT_COUNT_MAX constant.
  - Typedef for the stage-1 payload struct {hit}.
- Sub-module match_filter_table:
  - Holds the key/enable registers and the config write port.
  - Produces the combinational hit from in_a and in_b.
- The top level holds the pipeline, handshake and counter.

Test Plan:
- Setup write: A0=5, A1=3, B=5. Stream (a,b)=(2,3),(5,5),(3,5),(4,5), out_ready=1 -> out_c=15,0,0,15, each 2 cycles after its accept; hit_count=2.
- No config after reset; send (0,0) -> out_c=15, out_hit=0 (entries disabled).
- Hold out_ready=0 and stream 4 inputs -> in_ready drops after 2 accepted, out_c stable. Release -> results in order, no loss or duplication.
- Write A0=4 in the same cycle as accepting (4,5) -> miss. The next (4,5) -> hit.
- Pulse rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0 next cycle, hit_count=0, table cleared.
- With MATCH_FILTER_COUNT_EN, force 65537 hits -> hit_count=16'hFFFF. Without the macro -> hit_count=0 throughout.
